// File: rtl/accum_rmw_pipe.sv
`default_nettype none
// ============================================================================
// Module   : accum_rmw_pipe
// Purpose  : Pipelined read-modify-write accumulator for a row-partial-sum
//            memory held in an external simple-dual-port BRAM (1-cycle read
//            latency, read-first). One accumulation per clock, with forwarding
//            for back-to-back hits on a row. A clear sequencer zeroes rows
//            0..DEPTH-1 between tiles. SATURATE selects wrap-around (0) or
//            signed saturating (1) addition.
// Ports    : clk, reset (async, active-high)
//            in_valid/in_ready/in_row/in_prod : product input handshake
//            clear_start / clear_done          : clear request / done pulse
//            busy, sat_flag, acc_count         : status
//            rd_en/rd_addr/rd_data             : BRAM read port
//            wr_en/wr_addr/wr_data             : BRAM write port
// Revision : 1.0 - initial release
// ============================================================================
module accum_rmw_pipe #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,  // 1 <= DEPTH <= 2**ADDR_W
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_row,
  input  logic [DATA_W-1:0] in_prod,
  input  logic              clear_start,
  output logic              clear_done,
  output logic              busy,
  output logic              sat_flag,
  output logic [31:0]       acc_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] c_MAX       = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] c_MIN       = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [31:0]       c_CNT_MAX   = 32'hFFFF_FFFF;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic                w_ready_fsm;
  logic                w_clr_last;
  logic                w_accept;

  // Stage registers
  logic                r_s1_valid;
  logic [ADDR_W-1:0]   r_s1_row;
  logic [DATA_W-1:0]   r_s1_prod;
  logic                r_s2_valid;
  logic [ADDR_W-1:0]   r_s2_row;
  logic [DATA_W-1:0]   r_s2_sum;
  logic                r_s3_valid;
  logic [ADDR_W-1:0]   r_s3_row;
  logic [DATA_W-1:0]   r_s3_sum;

  logic [DATA_W-1:0]   w_operand;
  logic [DATA_W-1:0]   w_raw;
  logic [DATA_W-1:0]   w_sum;
  logic                w_clamp;

  logic                r_clear_done;
  logic                r_sat_flag;
  logic [31:0]         r_acc_count;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready_fsm = 1'b0;
    w_clr_last  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A clear request beats a simultaneous product.
        w_ready_fsm = ~clear_start;
        if (clear_start) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // S3 must be empty too so no stale forward survives into the clear.
        if (!r_s1_valid && !r_s2_valid && !r_s3_valid) begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (r_clr_addr == c_LAST_ADDR) begin
          w_clr_last  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_addr <= '0;
    end else if (r_state == ST_CLEAR && !w_clr_last) begin
      r_clr_addr <= r_clr_addr + c_ADDR_ONE;
    end else begin
      r_clr_addr <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // S0: accept and issue the BRAM read
  // --------------------------------------------------------------------------
  assign in_ready = w_ready_fsm & ~reset;
  assign w_accept = in_valid & in_ready;
  assign rd_en    = w_accept;
  assign rd_addr  = w_accept ? in_row : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_row   <= '0;
      r_s1_prod  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_row  <= in_row;
        r_s1_prod <= in_prod;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S1: operand select and add. The youngest in-flight write to the same row
  // wins; BRAM data is only current for rows not written in the last 2 cycles.
  // --------------------------------------------------------------------------
  always_comb begin
    w_operand = rd_data;
    if (r_s2_valid && (r_s2_row == r_s1_row)) begin
      w_operand = r_s2_sum;
    end else if (r_s3_valid && (r_s3_row == r_s1_row)) begin
      w_operand = r_s3_sum;
    end
  end

  assign w_raw = r_s1_prod + w_operand;

  generate
    if (SATURATE != 0) begin : g_sat
      logic w_ovf;
      // Overflow: operands share a sign and the result sign differs.
      assign w_ovf   = (r_s1_prod[DATA_W-1] == w_operand[DATA_W-1]) &&
                       (w_raw[DATA_W-1] != r_s1_prod[DATA_W-1]);
      assign w_sum   = w_ovf ? (r_s1_prod[DATA_W-1] ? c_MIN : c_MAX) : w_raw;
      assign w_clamp = w_ovf;
    end else begin : g_wrap
      assign w_sum   = w_raw;
      assign w_clamp = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // S2 (write) and S3 (last-written holding register)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_row   <= '0;
      r_s2_sum   <= '0;
      r_s3_valid <= 1'b0;
      r_s3_row   <= '0;
      r_s3_sum   <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_row <= r_s1_row;
        r_s2_sum <= w_sum;
      end
      r_s3_valid <= w_clr_last ? 1'b0 : r_s2_valid;
      if (r_s2_valid) begin
        r_s3_row <= r_s2_row;
        r_s3_sum <= r_s2_sum;
      end
    end
  end

  // Clear writes only happen in CLEAR, where S2 is guaranteed empty.
  assign wr_en   = r_s2_valid | (r_state == ST_CLEAR);
  assign wr_addr = (r_state == ST_CLEAR) ? r_clr_addr :
                   (r_s2_valid ? r_s2_row : '0);
  assign wr_data = r_s2_valid ? r_s2_sum : '0;

  // --------------------------------------------------------------------------
  // Status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clear_done <= 1'b0;
      r_sat_flag   <= 1'b0;
      r_acc_count  <= '0;
    end else begin
      r_clear_done <= w_clr_last;
      if (w_clr_last) begin
        r_sat_flag  <= 1'b0;
        r_acc_count <= '0;
      end else begin
        if (r_s1_valid && w_clamp) begin
          r_sat_flag <= 1'b1;
        end
        if (r_s2_valid && (r_acc_count != c_CNT_MAX)) begin
          r_acc_count <= r_acc_count + 32'd1;
        end
      end
    end
  end

  assign clear_done = r_clear_done;
  assign sat_flag   = r_sat_flag;
  assign acc_count  = r_acc_count;
  assign busy       = (r_state != ST_IDLE) | r_s1_valid | r_s2_valid;

endmodule
`default_nettype wire
